mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the processor's unified data bus, downstream of the multicycle core alongside `memory`. It decodes store cycles addressed to its two-word register window, buffers bytes in a small FIFO and serialises them as 8N1 frames on `txd`. It also supplies a combinational status read path and a hit flag, which `top` uses to steer `readdata` away from RAM.

---
 rtl/mmio_uart_tx.sv | 119 +++++++++++
 tb/tb_mmio_uart_tx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small TX FIFO and a STATUS register.
// Define UART_TX_IRQ_EN to add the ie bit and the registered TX-done irq output.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADR     = 32'h0000_0100,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] adr,
    input  logic [31:0] writedata,
    input  logic        memwrite,
    output logic        sel,
    output logic [31:0] readdata,
    output logic        txd,
    output logic        irq
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW-1:0] LAST = AW'(FIFO_DEPTH - 1);
    localparam logic [3:0] DEPTH = 4'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [3:0]    count;
    logic [CW-1:0] baud;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic          ovf, ie, busy, full, bit_end, push_req, push, pop, stat_wr;
    logic          unused_bits;

    assign sel         = adr[31:3] == BASE_ADR[31:3];
    assign push_req    = memwrite & sel & ~adr[2];
    assign stat_wr     = memwrite & sel & adr[2];
    assign busy        = state != IDLE;
    assign full        = count == DEPTH;
    assign bit_end     = baud == '0;
    assign pop         = (count != 4'd0) & ((state == IDLE) | ((state == STOP) & bit_end));
    assign push        = push_req & (~full | pop);
    assign readdata    = (sel & adr[2]) ? {24'b0, ie, 1'b0, ovf, count[2:0], full, busy} : '0;
    assign unused_bits = ^{writedata, adr[1:0]};

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= writedata[7:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            count <= count + {3'b0, push} - {3'b0, pop};
            if (push_req & ~push) ovf <= 1'b1;
            else if (stat_wr & writedata[5]) ovf <= 1'b0;
        end
    end

    // txd is registered: each transition loads the level of the bit being entered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            txd   <= 1'b1;
            baud  <= '0;
            idx   <= '0;
            shift <= '0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    state <= START;
                    shift <= mem[rd_ptr];
                    txd   <= 1'b0;
                    baud  <= RELOAD;
                end
                START: if (bit_end) begin
                    state <= DATA;
                    idx   <= '0;
                    txd   <= shift[0];
                    baud  <= RELOAD;
                end else baud <= baud - 1'b1;
                DATA: if (bit_end) begin
                    shift <= shift >> 1;
                    idx   <= idx + 3'd1;
                    baud  <= RELOAD;
                    state <= (idx == 3'd7) ? STOP : DATA;
                    txd   <= (idx == 3'd7) ? 1'b1 : shift[1];
                end else baud <= baud - 1'b1;
                STOP: if (bit_end) begin
                    state <= pop ? START : IDLE;
                    txd   <= ~pop;
                    baud  <= RELOAD;
                    if (pop) shift <= mem[rd_ptr];
                end else baud <= baud - 1'b1;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_TX_IRQ_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ie  <= 1'b0;
            irq <= 1'b0;
        end else begin
            if (stat_wr) ie <= writedata[7];
            irq <= ie & (count == 4'd0) & ~busy;
        end
    end
`else
    assign ie  = 1'b0;
    assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed stimulus with a serial-receiver monitor checking frames against a byte scoreboard.
module tb_mmio_uart_tx;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] adr = '0;
    logic [31:0] writedata = '0;
    logic        memwrite = 1'b0;
    logic        sel, txd, irq;
    logic [31:0] readdata;

    int vectors = 0, miscompares = 0, cyc = 0, frames_done = 0, irq_high = 0;
    logic [7:0] exp_q[$];
    int starts[$];

    mmio_uart_tx #(.BASE_ADR(32'h100), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .adr(adr), .writedata(writedata), .memwrite(memwrite),
        .sel(sel), .readdata(readdata), .txd(txd), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (irq === 1'b1) irq_high <= irq_high + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        adr = a;
        writedata = d;
        memwrite = 1'b1;
        @(negedge clk);
        memwrite = 1'b0;
    endtask

    task automatic status(output logic [31:0] d);
        adr = 32'h104;
        #1;
        d = readdata;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_frames(input int n);
        for (int i = 0; i < 800 && frames_done < n; i++) @(negedge clk);
        check("frames_done", frames_done, n);
    endtask

    function automatic int st(input int k);
        return (k < starts.size()) ? starts[k] : -1000;
    endfunction

    // Serial receiver: captures 40 samples per frame, checks shape and byte against the scoreboard
    initial begin : monitor
        logic [39:0] s;
        logic [7:0]  rb, ex;
        logic        shape, aborted, e;
        int          t0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && txd === 1'b0) begin
                t0 = cyc;
                s = '0;
                aborted = 1'b0;
                for (int k = 1; k < 40; k++) begin
                    @(negedge clk);
                    if (reset !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    s[k] = txd;
                end
                if (!aborted) begin
                    shape = 1'b1;
                    for (int b = 0; b < 10; b++) begin
                        e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : s[b*4+2];
                        for (int j = 0; j < 4; j++) if (s[b*4+j] !== e) shape = 1'b0;
                    end
                    for (int i = 0; i < 8; i++) rb[i] = s[(i+1)*4+2];
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_frame: got byte 0x%0h, expected no frame", rb);
                    end else begin
                        ex = exp_q.pop_front();
                        check("frame", {23'b0, shape, rb}, {23'b0, 1'b1, ex});
                    end
                    starts.push_back(t0);
                    frames_done++;
                end
            end
        end
    end

    initial begin : stim
        logic [31:0] d;
        int sc, nf;
        repeat (3) @(negedge clk);
        check("reset_hold_txd", txd, 1);
        reset = 1'b1;
        @(negedge clk);
        check("reset_txd", txd, 1);
        check("reset_irq", irq, 0);
        status(d);
        check("reset_status", d, 0);
        adr = 32'h0FC; #1;
        check("sel_0fc", sel, 0);
        check("rd_0fc", readdata, 0);
        adr = 32'h108; #1;
        check("sel_108", sel, 0);
        adr = 32'h100; #1;
        check("sel_100", sel, 1);
        check("rd_txdata", readdata, 0);

        exp_q.push_back(8'h55);
        store(32'h100, 32'h55);
        sc = cyc;
        wait_cyc(sc + 40);
        status(d);
        check("stop_busy", d, 32'h1);
        @(negedge clk);
        status(d);
        check("idle_after_frame", d, 0);
        wait_frames(1);
        check("frame1_start", st(0), sc + 1);

        for (int i = 1; i <= 6; i++) begin
            if (i <= 5) exp_q.push_back(8'(i));
            store(32'h100, 32'(i));
            if (i == 1) sc = cyc;
        end
        status(d);
        check("overflow_status", d, 32'h33);
        wait_frames(6);
        check("burst_start", st(1), sc + 1);
        for (int k = 2; k <= 5; k++) check("burst_contig", st(k) - st(k-1), 40);
        wait_cyc(sc + 203);
        status(d);
        check("ovf_sticky", d, 32'h20);
        store(32'h104, 32'h20);
        status(d);
        check("ovf_cleared", d, 0);

        for (int i = 1; i <= 6; i++) exp_q.push_back(8'(8'hA0 + i));
        store(32'h100, 32'hA1);
        sc = cyc;
        wait_cyc(sc + 36);
        for (int i = 2; i <= 5; i++) store(32'h100, 32'(8'hA0 + i));
        status(d);
        check("full_in_stop", d, 32'h13);
        store(32'h100, 32'hA6);
        status(d);
        check("push_on_pop", d, 32'h13);
        wait_frames(12);
        for (int k = 7; k <= 11; k++) check("fullpop_contig", st(k) - st(k-1), 40);
        wait_cyc(st(11) + 42);
        status(d);
        check("fullpop_idle", d, 0);

        store(32'h100, 32'hC3);
        sc = cyc;
        wait_cyc(sc + 19);
        check("data_bit3", txd, 0);
        reset = 1'b0;
        #1;
        check("reset_async_txd", txd, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        status(d);
        check("after_reset_status", d, 0);
        nf = frames_done;
        repeat (60) @(negedge clk);
        check("no_frame_after_reset", frames_done, nf);
        check("idle_txd", txd, 1);

`ifdef UART_TX_IRQ_EN
        store(32'h104, 32'h80);
        status(d);
        check("ie_set", d, 32'h80);
        exp_q.push_back(8'h5A);
        store(32'h100, 32'h5A);
        sc = cyc;
        wait_cyc(sc + 41);
        check("irq_at_idle_entry", irq, 0);
        @(negedge clk);
        check("irq_set", irq, 1);
        store(32'h104, 32'h0);
        @(negedge clk);
        check("irq_cleared", irq, 0);
`else
        store(32'h104, 32'h80);
        status(d);
        check("ie_absent", d, 0);
        exp_q.push_back(8'h5A);
        store(32'h100, 32'h5A);
        sc = cyc;
        wait_cyc(sc + 45);
        check("irq_never_high", irq_high, 0);
`endif
        wait_frames(13);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end
endmodule
